cordic_rr_sched: RTL and testbench
==================================

Name: cordic_rr_sched

Overview:
Round-robin scheduler that shares one iterative CORDIC engine between gp_nr_req requesters. Each requester offers an (x, y, z) operand set through a valid/ready handshake. The block grants one request, launches the engine with a start pulse, and waits for the engine's done pulse, guarded by a timeout. It then returns the result tagged with the requester ID on a single backpressured result port. It sits between the signal-generation/DSP clients and the shared iterative CORDIC datapath.

Parameters:
gp_nr_req, 4, number of requesters (2..16)
gp_xy_width, 8, x/y operand and result width (signed)
gp_z_width, 8, z operand and result width (signed)
gp_timeout, 64, maximum engine cycles from start to done before abort (>= gp_nr_iter+2)
gp_id_width, $clog2(gp_nr_req), requester ID width

Ports:
i_clk  in  1  clock, rising edge
i_rst_an  in  1  asynchronous active-low reset
i_req_valid  in  gp_nr_req  per-requester request valid
o_req_ready  out  gp_nr_req  per-requester accept (one-hot or zero)
i_req_x  in  gp_nr_req*gp_xy_width  packed x operands; requester k at [k*W +: W]
i_req_y  in  gp_nr_req*gp_xy_width  packed y operands
i_req_z  in  gp_nr_req*gp_z_width  packed z operands
o_eng_start  out  1  one-cycle engine load pulse
o_eng_x / o_eng_y  out  gp_xy_width  operands to engine, held stable from start until done
o_eng_z  out  gp_z_width  operand to engine
i_eng_done  in  1  engine result-valid pulse
i_eng_x / i_eng_y  in  gp_xy_width  engine results
i_eng_z  in  gp_z_width  engine result
o_res_valid  out  1  result valid
i_res_ready  in  1  result consumer ready
o_res_id  out  gp_id_width  requester ID of result
o_res_x / o_res_y  out  gp_xy_width  result
o_res_z  out  gp_z_width  result
o_res_err  out  1  result produced by timeout (data zeroed)
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rst_an=0): state=IDLE, rr pointer=gp_nr_req-1, all outputs 0, operand/result registers 0.
- State machine: IDLE -> START -> BUSY -> RESP -> IDLE.
- IDLE: o_req_ready is combinational; one-hot at the first asserted i_req_valid searching upward from (rr pointer+1) mod gp_nr_req, wrapping. Otherwise 0.
  - On a grant: latch operands and ID, set rr pointer = granted index, go to START.
  - o_req_ready is never asserted outside IDLE.
- START (1 cycle): o_eng_start=1 and the timeout counter is cleared. Go to BUSY.
- BUSY: the counter increments each cycle.
  - i_eng_done=1: capture i_eng_*, set o_res_err=0, go to RESP.
  - Counter reaches gp_timeout-1 without done: results=0, o_res_err=1, go to RESP.
  - Done and timeout in the same cycle: done wins (err=0).
- i_eng_done outside BUSY is ignored.
- RESP: o_res_valid=1 with o_res_id/x/y/z/err held stable. On i_res_valid&&i_res_ready, go to IDLE next cycle (o_res_valid drops).
- o_eng_x/y/z hold the latched operands from START through the end of BUSY. They are don't-care elsewhere but driven from the register, so no X.
- Latency from accept to o_res_valid = engine latency L (start-to-done cycles) + 2. Minimum accept-to-accept period = L+3 cycles.
- Requests not granted must keep i_req_valid asserted; no queueing inside the block.
- Fairness: with all requesters active, grants cycle 0,1,2,...,N-1,0. No requester waits more than N-1 other grants.
- Reset mid-operation: immediate return to IDLE. In-flight result discarded. rr pointer reset.
- No arithmetic beyond the counter; widths pass through unchanged.

Test Plan:
- Single request: req0 x=0x40, y=0, z=0x20; engine model done after 17 cycles returning x=0x27,y=0x1A,z=0x00 -> o_req_ready[0] in the same cycle, o_eng_start 1 cycle later, o_res_valid 19 cycles after accept, id=0, err=0, data matching.
- Round-robin: all 4 requesters valid continuously, i_res_ready=1 -> grant order 0,1,2,3,0,1; accepts 20 cycles apart with L=17.
- Backpressure: i_res_ready=0 for 10 cycles in RESP -> o_res_valid and data stable, no new o_req_ready until the handshake completes.
- Timeout: engine never asserts done, gp_timeout=64 -> o_res_valid with err=1, x=y=z=0, id correct; next request then served normally.
- Done at the final timeout cycle -> err=0 and engine data captured; a spurious i_eng_done in IDLE -> no effect.
- Reset asserted during BUSY -> all outputs 0 asynchronously. After release, rr restarts so requester 0 is granted first when all are valid.

Source files
------------

// File: rtl/cordic_rr_sched.sv
// Round-robin front end for one shared iterative CORDIC engine: arbitrates
// requesters, drives the engine, and returns ID-tagged results.
module cordic_rr_sched #(
  parameter int gp_nr_req   = 4,
  parameter int gp_xy_width = 8,
  parameter int gp_z_width  = 8,
  parameter int gp_timeout  = 64,
  parameter int gp_id_width = $clog2(gp_nr_req)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_an,
  input  logic [gp_nr_req-1:0]             i_req_valid,
  output logic [gp_nr_req-1:0]             o_req_ready,
  input  logic [gp_nr_req*gp_xy_width-1:0] i_req_x,
  input  logic [gp_nr_req*gp_xy_width-1:0] i_req_y,
  input  logic [gp_nr_req*gp_z_width-1:0]  i_req_z,
  output logic                             o_eng_start,
  output logic [gp_xy_width-1:0]           o_eng_x,
  output logic [gp_xy_width-1:0]           o_eng_y,
  output logic [gp_z_width-1:0]            o_eng_z,
  input  logic                             i_eng_done,
  input  logic [gp_xy_width-1:0]           i_eng_x,
  input  logic [gp_xy_width-1:0]           i_eng_y,
  input  logic [gp_z_width-1:0]            i_eng_z,
  output logic                             o_res_valid,
  input  logic                             i_res_ready,
  output logic [gp_id_width-1:0]           o_res_id,
  output logic [gp_xy_width-1:0]           o_res_x,
  output logic [gp_xy_width-1:0]           o_res_y,
  output logic [gp_z_width-1:0]            o_res_z,
  output logic                             o_res_err,
  output logic                             o_busy
);

  localparam int lp_cnt_w = $clog2(gp_timeout + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_RESP
  } t_state;

  t_state                         r_state;
  logic [gp_id_width-1:0]         r_ptr;
  logic [gp_id_width-1:0]         r_id;
  logic [lp_cnt_w-1:0]            r_cnt;
  logic signed [gp_xy_width-1:0]  r_op_x;
  logic signed [gp_xy_width-1:0]  r_op_y;
  logic signed [gp_z_width-1:0]   r_op_z;
  logic signed [gp_xy_width-1:0]  r_res_x;
  logic signed [gp_xy_width-1:0]  r_res_y;
  logic signed [gp_z_width-1:0]   r_res_z;
  logic [gp_id_width-1:0]         r_res_id;
  logic                           r_res_err;
  logic                           r_res_valid;
  logic                           r_eng_start;
  logic                           r_busy;

  logic [gp_id_width:0]           w_pick;
  logic                           w_gnt_vld;
  logic [gp_id_width-1:0]         w_gnt_idx;
  logic [gp_nr_req-1:0]           w_onehot;
  logic                           w_timeout;

  // First valid requester strictly after ptr, wrapping; MSB of result = found.
  function automatic logic [gp_id_width:0] f_rr_pick(
    input logic [gp_nr_req-1:0]   valid,
    input logic [gp_id_width-1:0] ptr
  );
    logic                   found;
    logic [gp_id_width-1:0] idx;
    logic [gp_nr_req-1:0]   sh;
    int                     k;
    found = 1'b0;
    idx   = '0;
    sh    = '0;
    k     = 0;
    for (int i = 1; i <= gp_nr_req; i++) begin
      k  = (int'(ptr) + i) % gp_nr_req;
      sh = valid >> k;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = gp_id_width'(k);
      end
    end
    return {found, idx};
  endfunction

  assign w_pick    = f_rr_pick(i_req_valid, r_ptr);
  assign w_gnt_vld = w_pick[gp_id_width];
  assign w_gnt_idx = w_pick[gp_id_width-1:0];
  assign w_onehot  = gp_nr_req'(1) << w_gnt_idx;
  assign w_timeout = (r_cnt == lp_cnt_w'(gp_timeout - 1));

  // Ready is gated by reset so every output reads zero while held in reset.
  assign o_req_ready = (i_rst_an && (r_state == ST_IDLE) && w_gnt_vld) ? w_onehot : '0;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_state     <= ST_IDLE;
      r_ptr       <= gp_id_width'(gp_nr_req - 1);
      r_id        <= '0;
      r_cnt       <= '0;
      r_op_x      <= '0;
      r_op_y      <= '0;
      r_op_z      <= '0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_z     <= '0;
      r_res_id    <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_op_x      <= i_req_x[int'(w_gnt_idx)*gp_xy_width +: gp_xy_width];
            r_op_y      <= i_req_y[int'(w_gnt_idx)*gp_xy_width +: gp_xy_width];
            r_op_z      <= i_req_z[int'(w_gnt_idx)*gp_z_width +: gp_z_width];
            r_id        <= w_gnt_idx;
            r_ptr       <= w_gnt_idx;
            r_eng_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_START;
          end
        end
        ST_START: begin
          r_cnt   <= '0;
          r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          // done takes priority over a timeout landing in the same cycle
          if (i_eng_done) begin
            r_res_x     <= i_eng_x;
            r_res_y     <= i_eng_y;
            r_res_z     <= i_eng_z;
            r_res_id    <= r_id;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_res_x     <= '0;
            r_res_y     <= '0;
            r_res_z     <= '0;
            r_res_id    <= r_id;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + lp_cnt_w'(1);
          end
        end
        ST_RESP: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_eng_start = r_eng_start;
  assign o_eng_x     = r_op_x;
  assign o_eng_y     = r_op_y;
  assign o_eng_z     = r_op_z;
  assign o_res_valid = r_res_valid;
  assign o_res_id    = r_res_id;
  assign o_res_x     = r_res_x;
  assign o_res_y     = r_res_y;
  assign o_res_z     = r_res_z;
  assign o_res_err   = r_res_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Directed bench for cordic_rr_sched: the engine is emulated step by step
// and every result is compared against hand-chosen values.
module tb_cordic_rr_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ZW = 8;
  localparam int IW = 2;

  logic            clk;
  logic            rst_an;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_x;
  logic [N*W-1:0]  req_y;
  logic [N*ZW-1:0] req_z;
  logic            eng_start;
  logic [W-1:0]    eng_x_o, eng_y_o;
  logic [ZW-1:0]   eng_z_o;
  logic            eng_done;
  logic [W-1:0]    eng_x_i, eng_y_i;
  logic [ZW-1:0]   eng_z_i;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_id;
  logic [W-1:0]    res_x, res_y;
  logic [ZW-1:0]   res_z;
  logic            res_err;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc = 0;
  bit chk_period = 1'b0;

  cordic_rr_sched #(
    .gp_nr_req(N), .gp_xy_width(W), .gp_z_width(ZW), .gp_timeout(64)
  ) dut (
    .i_clk(clk), .i_rst_an(rst_an),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
    .o_eng_start(eng_start), .o_eng_x(eng_x_o), .o_eng_y(eng_y_o), .o_eng_z(eng_z_o),
    .i_eng_done(eng_done), .i_eng_x(eng_x_i), .i_eng_y(eng_y_i), .i_eng_z(eng_z_i),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_id(res_id),
    .o_res_x(res_x), .o_res_y(res_y), .o_res_z(res_z), .o_res_err(res_err),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    req_x[k*W +: W]   = x;
    req_y[k*W +: W]   = y;
    req_z[k*ZW +: ZW] = z;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, eng_start, 0);
    chk({tag, "_rvalid"}, res_valid, 0);
    chk({tag, "_rdata"}, {res_id, res_err, res_x, res_y, res_z}, 0);
    chk({tag, "_edata"}, {eng_x_o, eng_y_o, eng_z_o}, 0);
  endtask

  // One full transaction: grant of requester id, engine done after lat
  // cycles with result (rx,ry,rz), then bp cycles of result backpressure.
  task automatic txn(input int id, input int lat, input logic [7:0] rx,
                     input logic [7:0] ry, input logic [7:0] rz, input int bp);
    int acc;
    logic [7:0] hx;
    #1;
    chk("grant", req_ready, 32'd1 << id);
    acc = cyc;
    if (chk_period) chk("period", acc - last_acc, lat + 3);
    last_acc = acc;
    tick();
    chk("start", eng_start, 1);
    chk("ready_in_start", req_ready, 0);
    chk("eng_ops", {eng_x_o, eng_y_o, eng_z_o},
        {req_x[id*W +: W], req_y[id*W +: W], req_z[id*ZW +: ZW]});
    repeat (lat) tick();
    chk("eng_ops_hold", {eng_x_o, eng_z_o}, {req_x[id*W +: W], req_z[id*ZW +: ZW]});
    eng_done = 1'b1;
    eng_x_i = rx; eng_y_i = ry; eng_z_i = rz;
    tick();
    eng_done = 1'b0;
    eng_x_i = 8'h55; eng_y_i = 8'h55; eng_z_i = 8'h55;
    res_ready = (bp == 0);
    chk("res_valid", res_valid, 1);
    chk("res_data", {res_id, res_err, res_x, res_y, res_z}, {id[IW-1:0], 1'b0, rx, ry, rz});
    chk("latency", cyc - acc, lat + 2);
    hx = res_x;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (i == bp - 1) res_ready = 1'b1;
      chk("bp_valid", res_valid, 1);
      chk("bp_data", {res_id, res_x}, {id[IW-1:0], hx});
      chk("bp_ready", req_ready, 0);
    end
    tick();
    chk("after_resp_valid", res_valid, 0);
    chk("after_resp_busy", busy, 0);
  endtask

  initial begin
    rst_an = 1'b0;
    req_valid = '1;
    req_x = '0; req_y = '0; req_z = '0;
    eng_done = 1'b0;
    eng_x_i = '0; eng_y_i = '0; eng_z_i = '0;
    res_ready = 1'b1;
    tick();
    tick();
    #1;
    chk_all_zero("reset");

    // Single request from requester 0
    set_req(0, 8'h40, 8'h00, 8'h20);
    req_valid = 4'b0001;
    rst_an = 1'b1;
    txn(0, 17, 8'h27, 8'h1A, 8'h00, 0);
    req_valid = '0;

    // Round-robin from a fresh reset with all requesters active
    rst_an = 1'b0;
    tick();
    rst_an = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 8'h10 + 8'(k), 8'hF0 + 8'(k), 8'h30 + 8'(k));
    req_valid = '1;
    txn(0, 17, 8'hA0, 8'hB0, 8'hC0, 0);
    chk_period = 1'b1;
    txn(1, 17, 8'hA1, 8'hB1, 8'hC1, 0);
    txn(2, 17, 8'hA2, 8'hB2, 8'hC2, 0);
    txn(3, 17, 8'hA3, 8'hB3, 8'hC3, 0);
    txn(0, 17, 8'h80, 8'h81, 8'h82, 0);
    txn(1, 17, 8'h7F, 8'h01, 8'hFF, 0);

    // Backpressure on the result port
    txn(2, 17, 8'hD2, 8'hE2, 8'h92, 10);
    chk_period = 1'b0;
    req_valid = '0;

    // Timeout: requester 1 only, engine never completes
    tick();
    req_valid = 4'b0010;
    set_req(1, 8'h11, 8'h22, 8'h33);
    #1;
    chk("to_grant", req_ready, 4'b0010);
    begin
      int acc;
      acc = cyc;
      tick();
      req_valid = '0;
      eng_x_i = 8'h5A; eng_y_i = 8'hA5; eng_z_i = 8'h3C;
      chk("to_start", eng_start, 1);
      repeat (64) tick();
      chk("to_not_yet", res_valid, 0);
      chk("to_busy", busy, 1);
      tick();
      chk("to_valid", res_valid, 1);
      chk("to_data", {res_id, res_err, res_x, res_y, res_z}, {2'd1, 1'b1, 24'h0});
      chk("to_latency", cyc - acc, 66);
      tick();
      chk("to_release", res_valid, 0);
    end

    // Normal service after a timeout
    req_valid = 4'b0100;
    set_req(2, 8'hC8, 8'h38, 8'h7F);
    txn(2, 17, 8'h12, 8'h34, 8'h56, 0);
    req_valid = '0;

    // Done on the very last timeout cycle wins over the abort
    req_valid = 4'b0001;
    set_req(0, 8'h01, 8'h02, 8'h03);
    txn(0, 64, 8'h9A, 8'hBC, 8'hDE, 0);
    req_valid = '0;

    // Spurious engine done while idle
    eng_done = 1'b1;
    eng_x_i = 8'h77; eng_y_i = 8'h77; eng_z_i = 8'h77;
    tick();
    chk("spur_valid", res_valid, 0);
    chk("spur_state", {busy, eng_start}, 0);
    tick();
    eng_done = 1'b0;
    chk("spur_data", {res_x, res_y, res_z, res_err}, {8'h9A, 8'hBC, 8'hDE, 1'b0});

    // Reset while the engine is busy
    req_valid = '1;
    #1;
    chk("mr_grant", req_ready, 4'b0010);
    tick();
    tick();
    tick();
    chk("mr_busy", busy, 1);
    rst_an = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_an = 1'b1;
    txn(0, 17, 8'h44, 8'h55, 8'h66, 0);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
